// File: rtl/pic_pkg.sv
// Shared PIC16F core definitions: power/WDT sequencer state encoding,
// OPTION and STATUS bit positions, and the WDT prescaler mask helper.
package pic_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SLEEP    = 2'd1,
        ST_WDT_RST  = 2'd2,
        ST_WDT_POST = 2'd3
    } wdt_state_t;

    // OPTION register fields
    localparam int OPT_PS_LSB = 0;
    localparam int OPT_PS_MSB = 2;
    localparam int OPT_PSA    = 3;

    // STATUS register bits owned by the WDT/SLEEP sequencer
    localparam int STATUS_PD  = 3;
    localparam int STATUS_TO  = 4;

    localparam int PRESCALE_W = 8;

    // Low ps bits of the prescaler that must be all-ones for a time-out;
    // ps=0 gives an empty mask, so every base tick times out.
    function automatic logic [PRESCALE_W-1:0] ps_mask(input logic [2:0] ps);
        return PRESCALE_W'((9'd1 << ps) - 9'd1);
    endfunction

endpackage

// File: rtl/wdt_counter.sv
// WDT base counter plus optional prescaler; produces the time-out strobe.
module wdt_counter
    import pic_pkg::*;
#(
    parameter int BASE_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clear,
    input  logic       psa,
    input  logic [2:0] ps,
    output logic       timeout
);

    logic [BASE_W-1:0]     base;
    logic [PRESCALE_W-1:0] pre;
    logic [PRESCALE_W-1:0] mask;
    logic                  base_tick;

    assign base_tick = en && (&base);
    assign mask      = ps_mask(ps);
    // ps/psa are sampled live, so a change applies at the next base tick
    assign timeout   = base_tick && (!psa || ((pre & mask) == mask));

    // Base runs every clock while enabled; prescaler advances once per base period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base <= '0;
            pre  <= '0;
        end else if (!en || clear) begin
            base <= '0;
            pre  <= '0;
        end else begin
            base <= base + BASE_W'(1);
            if (psa && base_tick)
                pre <= pre + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/wdt_sleep_controller.sv
// Watchdog and SLEEP sequencer: tracks RUN/SLEEP, issues WDT core resets
// and wakes, and drives the STATUS not-TO / not-PD write enables.
module wdt_sleep_controller
    import pic_pkg::*;
#(
    parameter int BASE_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wdt_en,
    input  logic       psa,
    input  logic [2:0] ps,
    input  logic       op_clrwdt,
    input  logic       op_sleep,
    input  logic       wake_event,
    output logic       sleeping,
    output logic       wdt_reset_req,
    output logic       wdt_wake,
    output logic       n_to_wr_en,
    output logic       n_to_in,
    output logic       n_pd_wr_en,
    output logic       n_pd_in
);

    wdt_state_t state, state_nx;
    logic       timeout;
    logic       clear;

    wdt_counter #(.BASE_W(BASE_W)) u_wdt_counter (
        .clk     (clk),
        .rst     (rst),
        .en      (wdt_en),
        .clear   (clear),
        .psa     (psa),
        .ps      (ps),
        .timeout (timeout)
    );

    // State register; sleeping is a flopped copy of (state == SLEEP)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_RUN;
            sleeping <= 1'b0;
        end else begin
            state    <= state_nx;
            sleeping <= (state_nx == ST_SLEEP);
        end
    end

    // Next state: RUN priority is sleep > clrwdt > timeout; in SLEEP timeout beats wake
    always_comb begin
        state_nx = state;
        case (state)
            ST_RUN: begin
                if (op_sleep)
                    state_nx = ST_SLEEP;
                else if (!op_clrwdt && timeout)
                    state_nx = ST_WDT_RST;
            end
            ST_SLEEP: begin
                if (timeout || wake_event)
                    state_nx = ST_RUN;
            end
            ST_WDT_RST:  state_nx = ST_WDT_POST;
            ST_WDT_POST: state_nx = ST_RUN;
            default:     state_nx = ST_RUN;
        endcase
    end

    // Outputs: status-bit writes, counter clear, reset/wake pulses
    always_comb begin
        clear         = 1'b0;
        wdt_reset_req = 1'b0;
        wdt_wake      = 1'b0;
        n_to_wr_en    = 1'b0;
        n_to_in       = 1'b1;
        n_pd_wr_en    = 1'b0;
        n_pd_in       = 1'b1;
        case (state)
            ST_RUN: begin
                if (op_sleep) begin
                    clear      = 1'b1;
                    n_to_wr_en = 1'b1;
                    n_pd_wr_en = 1'b1;
                    n_pd_in    = 1'b0;
                end else if (op_clrwdt) begin
                    clear      = 1'b1;
                    n_to_wr_en = 1'b1;
                    n_pd_wr_en = 1'b1;
                end else if (timeout) begin
                    clear      = 1'b1;
                end
            end
            ST_SLEEP: begin
                if (timeout) begin
                    clear      = 1'b1;
                    wdt_wake   = 1'b1;
                    n_to_wr_en = 1'b1;
                    n_to_in    = 1'b0;
                end
            end
            ST_WDT_RST: begin
                wdt_reset_req = 1'b1;
            end
            ST_WDT_POST: begin
                // Lands after the core reset so it overrides the STATUS reset value
                n_to_wr_en = 1'b1;
                n_to_in    = 1'b0;
                n_pd_wr_en = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wdt_sleep_controller.sv
// Self-checking bench for wdt_sleep_controller (BASE_W=4). A behavioural
// model predicts the output vector each cycle; predictions are queued when
// inputs are driven and popped when the outputs are sampled.
module tb_wdt_sleep_controller;

    localparam int BW = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wdt_en = 1'b1;
    logic       psa = 1'b0;
    logic [2:0] ps = 3'd0;
    logic       op_clrwdt = 1'b0;
    logic       op_sleep = 1'b0;
    logic       wake_event = 1'b0;
    logic       sleeping, wdt_reset_req, wdt_wake;
    logic       n_to_wr_en, n_to_in, n_pd_wr_en, n_pd_in;

    wdt_sleep_controller #(.BASE_W(BW)) dut (
        .clk           (clk),
        .rst           (rst),
        .wdt_en        (wdt_en),
        .psa           (psa),
        .ps            (ps),
        .op_clrwdt     (op_clrwdt),
        .op_sleep      (op_sleep),
        .wake_event    (wake_event),
        .sleeping      (sleeping),
        .wdt_reset_req (wdt_reset_req),
        .wdt_wake      (wdt_wake),
        .n_to_wr_en    (n_to_wr_en),
        .n_to_in       (n_to_in),
        .n_pd_wr_en    (n_pd_wr_en),
        .n_pd_in       (n_pd_in)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_no  = 0;
    int n_rreq, n_wake, rreq_cyc, wake_cyc;

    // model: state 0=RUN 1=SLEEP 2=WDT_RST 3=WDT_POST; m_el = clocks since clear
    int m_st = 0;
    int m_el = 0;

    logic [6:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_to();
        int period;
        period = (1 << BW) * (psa ? (1 << ps) : 1);
        return wdt_en && ((m_el % period) == period - 1);
    endfunction

    // {sleeping, reset_req, wake, to_wr, to_in, pd_wr, pd_in}
    function automatic logic [6:0] model_out(input logic sl, input logic ck);
        logic s, rr, wk, tw, ti, pw, pi;
        s = (m_st == 1); rr = 0; wk = 0; tw = 0; ti = 1; pw = 0; pi = 1;
        case (m_st)
            0: if (sl) begin tw = 1; pw = 1; pi = 0; end
               else if (ck) begin tw = 1; pw = 1; end
            1: if (model_to()) begin tw = 1; ti = 0; wk = 1; end
            2: rr = 1;
            3: begin tw = 1; ti = 0; pw = 1; end
            default: ;
        endcase
        return {s, rr, wk, tw, ti, pw, pi};
    endfunction

    task automatic model_adv(input logic sl, input logic ck, input logic wk);
        bit to, clr;
        int nst;
        to = model_to(); clr = 0; nst = m_st;
        case (m_st)
            0: if (sl) begin clr = 1; nst = 1; end
               else if (ck) clr = 1;
               else if (to) begin clr = 1; nst = 2; end
            1: if (to) begin clr = 1; nst = 0; end
               else if (wk) nst = 0;
            2: nst = 3;
            default: nst = 0;
        endcase
        if (!wdt_en || clr) m_el = 0; else m_el++;
        m_st = nst;
    endtask

    task automatic pop_check(input string tag);
        logic [6:0] exp;
        exp = sb.pop_front();
        chk(tag, {25'd0, sleeping, wdt_reset_req, wdt_wake, n_to_wr_en, n_to_in,
                  n_pd_wr_en, n_pd_in}, {25'd0, exp});
    endtask

    // One clock: drive at negedge, check mid-low-phase, advance model at posedge
    task automatic cyc(input logic sl, input logic ck, input logic wk);
        op_sleep = sl; op_clrwdt = ck; wake_event = wk;
        cyc_no++;
        sb.push_back(model_out(sl, ck));
        #2;
        pop_check($sformatf("out_c%0d", cyc_no));
        if (wdt_reset_req) begin n_rreq++; rreq_cyc = cyc_no; end
        if (wdt_wake) begin n_wake++; wake_cyc = cyc_no; end
        @(posedge clk);
        model_adv(sl, ck, wk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        op_sleep = 0; op_clrwdt = 0; wake_event = 0;
        rst = 1;
        m_st = 0; m_el = 0;
        #1;
        sb.push_back(model_out(1'b0, 1'b0));
        pop_check("reset");
        @(negedge clk);
        rst = 0;
        cyc_no = 0; n_rreq = 0; n_wake = 0; rreq_cyc = -1; wake_cyc = -1;
    endtask

    initial begin
        // T1: free-running timeout in RUN
        wdt_en = 1; psa = 0; ps = 0;
        #2;
        do_reset();
        for (int i = 0; i < 20; i++) cyc(0, 0, 0);
        chk("rreq_cycle", rreq_cyc, 17);
        chk("rreq_count", n_rreq, 1);

        // T2: CLRWDT every 10 cycles keeps the core alive
        do_reset();
        for (int i = 1; i <= 60; i++) cyc(0, (i % 10) == 0, 0);
        chk("clrwdt_no_rreq", n_rreq, 0);

        // T3: SLEEP with prescaler 4, WDT wake after 64 cycles; ops ignored in SLEEP
        psa = 1; ps = 3'd2;
        do_reset();
        cyc(1, 0, 0);
        for (int i = 2; i <= 70; i++) cyc(i == 20, i == 10, 0);
        chk("wake_cycle", wake_cyc, 65);
        chk("wake_count", n_wake, 1);

        // T4: wake_event wakes without status writes
        psa = 0; ps = 0;
        do_reset();
        cyc(1, 0, 0);
        for (int i = 2; i <= 12; i++) cyc(0, 0, i == 6);
        chk("event_no_wdt_wake", n_wake, 0);

        // T5: CLRWDT in the timeout cycle
        do_reset();
        for (int i = 1; i <= 25; i++) cyc(0, i == 16, 0);
        chk("clr_at_to_no_rreq", n_rreq, 0);

        // T6: timeout and wake_event together in SLEEP
        do_reset();
        cyc(1, 0, 0);
        for (int i = 2; i <= 20; i++) cyc(0, 0, i == 17);
        chk("to_wake_cycle", wake_cyc, 17);
        chk("to_wake_count", n_wake, 1);

        // T7: rst in WDT_RST cancels the sequence
        do_reset();
        for (int i = 0; i < 16; i++) cyc(0, 0, 0);
        op_sleep = 0; op_clrwdt = 0; wake_event = 0;
        cyc_no++;
        sb.push_back(model_out(1'b0, 1'b0));
        #2;
        pop_check("in_wdt_rst");
        #1;
        rst = 1;
        m_st = 0; m_el = 0;
        #1;
        sb.push_back(model_out(1'b0, 1'b0));
        pop_check("rst_async");
        @(negedge clk);
        rst = 0;
        n_rreq = 0;
        for (int i = 0; i < 5; i++) cyc(0, 0, 0);
        chk("no_post_rreq", n_rreq, 0);

        // T8: watchdog disabled
        wdt_en = 0;
        do_reset();
        for (int i = 0; i < 10000; i++) cyc(0, 0, 0);
        chk("dis_no_rreq", n_rreq, 0);
        chk("dis_no_wake", n_wake, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
